// File: rtl/ctrl_reg_arbiter.sv
// ctrl_reg_arbiter: shares one register-file BRAM port among NUM_REQ requesters, one access at a time.
// Optional CTRL_ARB_HOST_PRIO_EN: requester 0 has strict priority; the rest round-robin among themselves.
module ctrl_reg_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned RD_LAT  = 3,
  parameter int unsigned WR_LAT  = 2
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [NUM_REQ-1:0]    s_req_valid,
  output logic [NUM_REQ-1:0]    s_req_ready,
  input  logic [NUM_REQ-1:0]    s_req_we,
  input  logic [NUM_REQ*12-1:0] s_req_addr,
  input  logic [NUM_REQ*32-1:0] s_req_wdata,
  output logic [NUM_REQ-1:0]    m_rsp_valid,
  output logic [31:0]           m_rsp_data,
  output logic                  bram_en_a,
  output logic [3:0]            bram_we_a,
  output logic [11:0]           bram_addr_a,
  output logic [31:0]           bram_wrdata_a,
  input  logic [31:0]           bram_rddata_a,
  output logic                  busy
);

  localparam int unsigned AW      = 12;
  localparam int unsigned DW      = 32;
  localparam int unsigned GW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic                 we_q, we_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]        rsp_data_q, rsp_data_d;
  logic                 en_q, en_d;
  logic [3:0]           bram_we_q, bram_we_d;
  logic [AW-1:0]        bram_addr_q, bram_addr_d;
  logic [DW-1:0]        wrdata_q, wrdata_d;
  logic                 busy_q, busy_d;

  logic                 win_found;
  logic [GW-1:0]        win_idx;
  logic                 win_we;
  logic [AW-1:0]        win_addr;
  logic [DW-1:0]        win_wdata;
  logic                 hs;

  // Winner search starting just after the last round-robin grant
  always_comb begin
    logic [GW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
`ifdef CTRL_ARB_HOST_PRIO_EN
    if (s_req_valid[0]) begin
      win_found = 1'b1;
    end
    for (int unsigned k = 1; k < NUM_REQ; k++) begin
      cand = GW'(((32'(last_grant_q) + NUM_REQ - 2 + k) % (NUM_REQ - 1)) + 1);
      if (!win_found && s_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`else
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && s_req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  assign win_we    = s_req_we[win_idx];
  assign win_addr  = s_req_addr[AW*win_idx +: AW];
  assign win_wdata = s_req_wdata[DW*win_idx +: DW];
  assign hs        = (state_q == IDLE) && !user_reset && win_found;

  always_comb begin
    s_req_ready = '0;
    if (hs) begin
      s_req_ready[win_idx] = 1'b1;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    en_d         = 1'b0;
    bram_we_d    = 4'h0;
    bram_addr_d  = '0;
    wrdata_d     = wrdata_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          state_d     = ISSUE;
          grant_d     = win_idx;
          we_d        = win_we;
          en_d        = 1'b1;
          bram_we_d   = win_we ? 4'hF : 4'h0;
          bram_addr_d = win_addr & 12'hFFC;
          wrdata_d    = win_wdata;
`ifdef CTRL_ARB_HOST_PRIO_EN
          if (win_idx != '0) begin
            last_grant_d = win_idx;
          end
`else
          last_grant_d = win_idx;
`endif
        end
      end
      ISSUE: begin
        cnt_d   = we_q ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (!we_q) begin
            rsp_data_d = bram_rddata_a;
          end
          rsp_valid_d[grant_q] = 1'b1;
          state_d              = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_REQ - 1);
      grant_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      en_q         <= 1'b0;
      bram_we_q    <= 4'h0;
      bram_addr_q  <= '0;
      wrdata_q     <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      en_q         <= en_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      wrdata_q     <= wrdata_d;
      busy_q       <= busy_d;
    end
  end

  assign m_rsp_valid   = rsp_valid_q;
  assign m_rsp_data    = rsp_data_q;
  assign bram_en_a     = en_q;
  assign bram_we_a     = bram_we_q;
  assign bram_addr_a   = bram_addr_q;
  assign bram_wrdata_a = wrdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_ctrl_reg_arbiter.sv
// tb_ctrl_reg_arbiter: directed and random requests checked cycle by cycle against a transaction-level model.
module tb_ctrl_reg_arbiter;

  localparam int N      = 3;
  localparam int RD_LAT = 3;
  localparam int WR_LAT = 2;

  logic            user_clk = 1'b0;
  logic            user_reset;
  logic [N-1:0]    s_req_valid, s_req_ready, s_req_we, m_rsp_valid;
  logic [N*12-1:0] s_req_addr;
  logic [N*32-1:0] s_req_wdata;
  logic [31:0]     m_rsp_data, bram_wrdata_a, bram_rddata_a;
  logic            bram_en_a, busy;
  logic [3:0]      bram_we_a;
  logic [11:0]     bram_addr_a;

  ctrl_reg_arbiter #(.NUM_REQ(N), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .user_clk(user_clk), .user_reset(user_reset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
    .s_req_addr(s_req_addr), .s_req_wdata(s_req_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rsp_data(m_rsp_data),
    .bram_en_a(bram_en_a), .bram_we_a(bram_we_a), .bram_addr_a(bram_addr_a),
    .bram_wrdata_a(bram_wrdata_a), .bram_rddata_a(bram_rddata_a), .busy(busy)
  );

  always #5 user_clk = ~user_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Requester drivers
  logic        act [N];
  logic        a_we[N];
  logic [11:0] a_addr[N];
  logic [31:0] a_wd[N];
  logic [N-1:0] rdy_obs = '0;

  // Register-file responder contents and the model's own shadow copy
  logic [31:0] bmem[1024];
  logic [31:0] shadow[1024];
  int          ret_cyc = -1;
  logic [31:0] ret_word;

  // Transaction-level model state
  bit          seen_reset = 0;
  int          m_lg = N - 1;
  int          next_hs = 0, en_cyc = -1, rsp_cyc = -1;
  int          p_g = 0;
  logic        p_we = 1'b0;
  logic [11:0] p_addr = '0;
  logic [31:0] p_wdata = '0, p_rdata = '0;
  logic [31:0] exp_wrdata = '0, exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
    end
  endtask

  // Requester closest after the last grant in circular order wins
  function automatic int pick(input logic [N-1:0] v, input int lg);
    int best, bd, d;
    best = -1;
    bd   = 2 * N;
`ifdef CTRL_ARB_HOST_PRIO_EN
    if (v[0]) return 0;
    for (int i = 1; i < N; i++) begin
      d = (i - lg - 1 + 2 * (N - 1)) % (N - 1);
      if (v[i] && d < bd) begin bd = d; best = i; end
    end
`else
    for (int i = 0; i < N; i++) begin
      d = (i - lg - 1 + 2 * N) % N;
      if (v[i] && d < bd) begin bd = d; best = i; end
    end
`endif
    return best;
  endfunction

  task automatic model_check();
    int win;
    logic [N-1:0] exp_rdy, exp_rsp;
    win = -1;
    if (!user_reset && cyc >= next_hs) win = pick(s_req_valid, m_lg);
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    exp_rsp = '0;
    if (cyc == rsp_cyc) exp_rsp[p_g] = 1'b1;
    if (cyc == en_cyc) exp_wrdata = p_wdata;
    if (cyc == rsp_cyc && !p_we) exp_rdata = p_rdata;
    rdy_obs = s_req_ready;
    if (seen_reset) begin
      chk("ready", 32'(s_req_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(cyc < next_hs));
      chk("bram_en", 32'(bram_en_a), 32'(cyc == en_cyc));
      chk("bram_we", 32'(bram_we_a), (cyc == en_cyc && p_we) ? 32'hF : 32'h0);
      chk("bram_addr", 32'(bram_addr_a), (cyc == en_cyc) ? 32'(p_addr & 12'hFFC) : 32'h0);
      chk("bram_wrdata", bram_wrdata_a, exp_wrdata);
      chk("rsp_valid", 32'(m_rsp_valid), 32'(exp_rsp));
      chk("rsp_data", m_rsp_data, exp_rdata);
    end
    if (user_reset) begin
      seen_reset = 1;
      next_hs = cyc + 1; en_cyc = -1; rsp_cyc = -1; m_lg = N - 1;
      exp_wrdata = '0; exp_rdata = '0;
    end else if (win >= 0) begin
      p_g     = win;
      p_we    = s_req_we[win];
      p_addr  = s_req_addr[12*win +: 12];
      p_wdata = s_req_wdata[32*win +: 32];
      en_cyc  = cyc + 1;
      rsp_cyc = cyc + 2 + (p_we ? WR_LAT : RD_LAT);
      next_hs = rsp_cyc + 1;
`ifdef CTRL_ARB_HOST_PRIO_EN
      if (win != 0) m_lg = win;
`else
      m_lg = win;
`endif
      if (p_we) shadow[p_addr[11:2]] = p_wdata;
      else p_rdata = shadow[p_addr[11:2]];
    end
  endtask

  task automatic bram_respond();
    if (bram_en_a && bram_we_a == 4'hF) bmem[bram_addr_a[11:2]] = bram_wrdata_a;
    if (bram_en_a && bram_we_a == 4'h0) begin
      ret_cyc  = cyc + RD_LAT;
      ret_word = bmem[bram_addr_a[11:2]];
    end
    bram_rddata_a = (cyc == ret_cyc) ? ret_word : $urandom;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_req_valid[i]           = act[i];
      s_req_we[i]              = a_we[i];
      s_req_addr[12*i +: 12]   = a_addr[i];
      s_req_wdata[32*i +: 32]  = a_wd[i];
    end
  endtask

  task automatic tick();
    @(negedge user_clk);
    model_check();
    @(posedge user_clk);
    cyc++;
    #1;
    bram_respond();
  endtask

  task automatic new_req(input int i);
    act[i]    = 1'b1;
    a_we[i]   = 1'($urandom_range(0, 1));
    a_addr[i] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
    a_wd[i]   = $urandom;
  endtask

  task automatic do_req(input int i, input logic we, input logic [11:0] addr, input logic [31:0] wd);
    int t;
    t = 0;
    act[i] = 1'b1; a_we[i] = we; a_addr[i] = addr; a_wd[i] = wd;
    drive();
    tick();
    while (!rdy_obs[i] && t < 40) begin tick(); t++; end
    if (!rdy_obs[i]) chk("hs_timeout", 32'(rdy_obs[i]), 32'h1);
    act[i] = 1'b0;
    drive();
  endtask

  task automatic pulse_reset();
    user_reset = 1'b1;
    tick();
    user_reset = 1'b0;
  endtask

  int g_id[$];
  int g_cy[$];

  initial begin
    for (int i = 0; i < 1024; i++) begin
      bmem[i]   = 32'(i) * 32'h9E3779B9;
      shadow[i] = 32'(i) * 32'h9E3779B9;
    end
    bmem[12'h800 >> 2]   = 32'h12345678;
    shadow[12'h800 >> 2] = 32'h12345678;
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0; a_we[i] = 1'b0; a_addr[i] = '0; a_wd[i] = '0;
    end
    drive();
    bram_rddata_a = '0;
    user_reset    = 1'b1;
    repeat (3) tick();
    user_reset = 1'b0;
    tick();

    // Single write, then single read of an unaligned address
    do_req(0, 1'b1, 12'h214, 32'hDEADBEEF);
    repeat (6) tick();
    do_req(1, 1'b0, 12'h803, 32'h0);
    repeat (7) tick();

    // Two requesters contending with back-to-back reads after a reset
    pulse_reset();
    act[0] = 1'b1; a_we[0] = 1'b0; a_addr[0] = 12'h10;
    act[1] = 1'b1; a_we[1] = 1'b0; a_addr[1] = 12'h20;
    drive();
    for (int k = 0; k < 40; k++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        if (rdy_obs[i]) begin
          g_id.push_back(i);
          g_cy.push_back(cyc - 1);
          a_addr[i] = 12'($urandom_range(0, 255));
        end
      end
      drive();
    end
    act[0] = 1'b0; act[1] = 1'b0; drive();
    repeat (8) tick();
`ifndef CTRL_ARB_HOST_PRIO_EN
    chk("contend_count", 32'(g_id.size()), 32'd7);
    for (int k = 0; k < g_id.size(); k++) begin
      chk("contend_order", 32'(g_id[k]), 32'(k % 2));
      if (k > 0) chk("contend_gap", 32'(g_cy[k] - g_cy[k-1]), 32'(RD_LAT + 3));
    end
`endif

    // Reset in the middle of a read, then a fresh read
    do_req(2, 1'b0, 12'h40, 32'h0);
    repeat (2) tick();
    pulse_reset();
    repeat (3) tick();
    do_req(2, 1'b0, 12'h800, 32'h0);
    repeat (7) tick();

    // Request raised and withdrawn while another access is in flight
    do_req(0, 1'b0, 12'h4, 32'h0);
    act[1] = 1'b1; a_we[1] = 1'b1; a_addr[1] = 12'h8; a_wd[1] = 32'hA5A5A5A5;
    drive();
    repeat (2) tick();
    act[1] = 1'b0; drive();
    repeat (10) tick();

    // Random traffic with withdrawals and occasional resets
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (rdy_obs[i]) act[i] = 1'b0;
        if (!act[i]) begin
          if ($urandom_range(0, 5) == 0) new_req(i);
        end else if ($urandom_range(0, 31) == 0) begin
          act[i] = 1'b0;
        end
      end
      user_reset = ($urandom_range(0, 299) == 0);
      drive();
      tick();
    end
    user_reset = 1'b0;
    for (int i = 0; i < N; i++) act[i] = 1'b0;
    drive();
    repeat (10) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ctrl_reg_arbiter.md
# ctrl_reg_arbiter

Shares the single BRAM-style control-register port of the register file between several on-chip requesters: host AXI-lite bridge, TLB loader, command engines. Accepts one request at a time through per-requester valid/ready channels and arbitrates round-robin. It drives one read or write access on the register-file port, then returns a completion pulse, with read data for reads, to the granted requester. It sits between the requesters and the register-file port in the user clock domain.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- RD_LAT, 3, cycles from bram_en_a pulse to valid bram_rddata_a (≥1)
- WR_LAT, 2, cycles from write bram_en_a pulse until the register file accepts a new access (≥1)

Ports:
- user_clk  in  1  sole clock
- user_reset  in  1  synchronous, active-high reset
- s_req_valid  in  NUM_REQ  request pending, per requester
- s_req_ready  out  NUM_REQ  request accepted, per requester (one-hot or zero)
- s_req_we  in  NUM_REQ  1 = write, 0 = read
- s_req_addr  in  NUM_REQ*12  byte address, requester i at [12i+11:12i]
- s_req_wdata  in  NUM_REQ*32  write data, requester i at [32i+31:32i]
- m_rsp_valid  out  NUM_REQ  one-cycle completion pulse, per requester
- m_rsp_data  out  32  read data, shared; valid with any m_rsp_valid bit on a read
- bram_en_a  out  1  access strobe, one cycle per access
- bram_we_a  out  4  4'hF on write, 4'h0 on read
- bram_addr_a  out  12  word-aligned byte address, bits [1:0] forced 0
- bram_wrdata_a  out  32  write data
- bram_rddata_a  in  32  read data from register file
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE: if any s_req_valid is set, pick winner g combinationally and assert s_req_ready[g] in the same cycle. Latch we/addr/wdata of g and go to ISSUE. With no valid request, stay in IDLE.
- Round-robin: search starts at last_grant+1 mod NUM_REQ and takes the first valid requester. last_grant updates on each handshake and resets to NUM_REQ-1, so requester 0 has first priority after reset.
- ISSUE: bram_en_a=1 for exactly one cycle with latched we/addr/wdata. Load counter with (we ? WR_LAT : RD_LAT)-1 and go to WAIT.
- WAIT: decrement the counter. At 0, capture bram_rddata_a into m_rsp_data (reads only; on writes m_rsp_data holds its value) and go to RESP.
- RESP: m_rsp_valid[g]=1 for one cycle, then IDLE. Responses are not backpressured.
- A requester must hold valid and payload stable until ready. Deasserting valid before ready is allowed and withdraws the request.
- Only one access is outstanding at any time. No pipelining.

## Timing
- Reset: state=IDLE, last_grant=NUM_REQ-1, s_req_ready=0, m_rsp_valid=0, m_rsp_data=0, bram_en_a=0, bram_we_a=0, bram_addr_a=0, bram_wrdata_a=0, busy=0.
- Handshake in cycle 0 → bram_en_a in cycle 1. Read: m_rsp_valid in cycle 1+RD_LAT+1 (5 at default). Write: m_rsp_valid in cycle 1+WR_LAT+1 (4 at default).
- Next handshake is possible in the cycle after RESP. Read throughput: 1 access per RD_LAT+3 cycles.
- s_req_ready is never asserted outside IDLE. A new valid arriving during a transfer waits.
- Reset mid-operation: abort immediately, suppress the pending m_rsp_valid, drop bram_en_a, return to IDLE.
- bram_en_a, bram_we_a, bram_addr_a and bram_wrdata_a are registered. bram_we_a and bram_addr_a are 0 outside ISSUE.

## Configuration
- CTRL_ARB_HOST_PRIO_EN defined: requester 0 has strict priority and wins whenever its valid is set in IDLE. Requesters 1..NUM_REQ-1 are round-robin among themselves. Requester 0 grants do not update last_grant.
- Not defined: plain round-robin over all NUM_REQ requesters as described above.

## Test plan
- Single write: req0 we=1, addr=0x214, wdata=0xDEADBEEF at cycle 0. Expect ready0 in cycle 0, bram_en_a=1 with we=4'hF, addr=0x214, data=0xDEADBEEF in cycle 1, m_rsp_valid[0] in cycle 4.
- Single read: req1 we=0, addr=0x803; the model returns 0x12345678 RD_LAT cycles after en. Expect bram_addr_a=0x800, m_rsp_valid[1] with m_rsp_data=0x12345678 in cycle 5.
- Contention: req0 and req1 both continuously valid with reads. Expect grants alternating 1? No: expect 0,1,0,1 starting with 0 after reset, one grant every 6 cycles, never two ready bits at once.
- Host priority: with CTRL_ARB_HOST_PRIO_EN defined, NUM_REQ=3, all valid. Expect req0 granted every time. With req0 idle, expect grants alternating 1,2.
- Reset mid-read: assert user_reset in WAIT. Expect no m_rsp_valid, busy=0 the cycle after reset, and a fresh request completing normally after reset releases.
- Withdrawn request: req1 valid raised and dropped while busy. Expect no grant to req1 and no bram_en_a for it.
